// File: rtl/nrzi_pkg.sv
// Shared constants and types for the NRZI receive deserialiser.
//   DATA_W      payload byte width
//   SYNC_FLAG   opening/closing frame flag
//   MAX_FRAME   payload bytes allowed per frame before abort
//   BYTE_CNT_W  width of the per-frame byte counter (holds 0..MAX_FRAME)
//   BIT_CNT_W   width of the bit-within-byte counter
//   state_e     framing FSM states
package nrzi_pkg;

    localparam int unsigned DATA_W     = 8;
    localparam logic [7:0]  SYNC_FLAG  = 8'h7E;
    localparam int unsigned MAX_FRAME  = 16;
    localparam int unsigned BYTE_CNT_W = $clog2(MAX_FRAME + 1);
    localparam int unsigned BIT_CNT_W  = 3;

    typedef enum logic {
        HUNT = 1'b0,
        RECV = 1'b1
    } state_e;

endpackage

// File: rtl/nrzi_rx_deser_if.sv
// Byte hand-off channel from the deserialiser to its consumer.
//   data_out    received payload byte (producer -> consumer)
//   data_valid  byte available (producer -> consumer)
//   data_ready  consumer accepts the byte (consumer -> producer)
interface nrzi_rx_deser_if;
    import nrzi_pkg::*;

    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              data_ready;

    modport master (
        output data_out,
        output data_valid,
        input  data_ready
    );

    modport slave (
        input  data_out,
        input  data_valid,
        output data_ready
    );

endinterface

// File: rtl/nrzi_bit_decoder.sv
// NRZI line decoder: a held line is a 1, a toggled line is a 0.
//   clock, reset  system clock, async active-low reset
//   rx_in         synchronised NRZI line
//   rx_en         bit strobe; rx_in only meaningful when high
//   dec_bit_c     decoded bit for the current strobe (combinational)
//   bit_stb_c     decoded bit is valid this cycle (combinational)
module nrzi_bit_decoder (
    input  logic clock,
    input  logic reset,
    input  logic rx_in,
    input  logic rx_en,
    output logic dec_bit_c,
    output logic bit_stb_c
);

    logic prev_line_q;

    // Previous line level; idle line is high so it resets to 1.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            prev_line_q <= 1'b1;
        end else if (rx_en) begin
            prev_line_q <= rx_in;
        end
    end

    assign dec_bit_c = (rx_in == prev_line_q);
    assign bit_stb_c = rx_en;

endmodule

// File: rtl/nrzi_rx_deser.sv
// NRZI receive deserialiser: flag hunt, LSB-first byte assembly,
// single-entry holding register with valid/ready hand-off.
//   clock, reset  system clock, async active-low reset
//   rx_in, rx_en  NRZI line and bit strobe
//   dout          byte channel (master side)
//   frame_active  high between opening flag and closing flag / abort
//   frame_end     one-cycle pulse on closing flag
//   err_length    one-cycle pulse when a frame exceeds MAX_FRAME bytes
//   err_overrun   sticky; byte dropped because holding register was full
//   clr_err       synchronous clear of err_overrun
module nrzi_rx_deser
    import nrzi_pkg::*;
(
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   rx_in,
    input  logic                   rx_en,
    input  logic                   clr_err,
    nrzi_rx_deser_if.master        dout,
    output logic                   frame_active,
    output logic                   frame_end,
    output logic                   err_length,
    output logic                   err_overrun
);

    logic dec_bit_c;
    logic bit_stb_c;

    nrzi_bit_decoder u_dec (
        .clock     (clock),
        .reset     (reset),
        .rx_in     (rx_in),
        .rx_en     (rx_en),
        .dec_bit_c (dec_bit_c),
        .bit_stb_c (bit_stb_c)
    );

    state_e                state_q,        state_d;
    logic [7:0]            hunt_q,         hunt_d;
    logic [DATA_W-1:0]     shift_q,        shift_d;
    logic [BIT_CNT_W-1:0]  bit_cnt_q,      bit_cnt_d;
    logic [BYTE_CNT_W-1:0] byte_cnt_q,     byte_cnt_d;
    logic                  frame_active_q, frame_active_d;
    logic                  frame_end_q,    frame_end_d;
    logic                  err_length_q,   err_length_d;
    logic                  err_overrun_q,  err_overrun_d;
    logic [DATA_W-1:0]     data_out_q,     data_out_d;
    logic                  data_valid_q,   data_valid_d;
    logic                  new_byte_c;

    // State register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q        <= HUNT;
            hunt_q         <= '0;
            shift_q        <= '0;
            bit_cnt_q      <= '0;
            byte_cnt_q     <= '0;
            frame_active_q <= 1'b0;
            frame_end_q    <= 1'b0;
            err_length_q   <= 1'b0;
            err_overrun_q  <= 1'b0;
            data_out_q     <= '0;
            data_valid_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            hunt_q         <= hunt_d;
            shift_q        <= shift_d;
            bit_cnt_q      <= bit_cnt_d;
            byte_cnt_q     <= byte_cnt_d;
            frame_active_q <= frame_active_d;
            frame_end_q    <= frame_end_d;
            err_length_q   <= err_length_d;
            err_overrun_q  <= err_overrun_d;
            data_out_q     <= data_out_d;
            data_valid_q   <= data_valid_d;
        end
    end

    // Framing FSM: flag hunt, byte assembly, closing flag and length abort.
    always_comb begin
        state_d        = state_q;
        hunt_d         = hunt_q;
        shift_d        = shift_q;
        bit_cnt_d      = bit_cnt_q;
        byte_cnt_d     = byte_cnt_q;
        frame_active_d = frame_active_q;
        frame_end_d    = 1'b0;
        err_length_d   = 1'b0;
        new_byte_c     = 1'b0;

        if (bit_stb_c) begin
            case (state_q)
                HUNT: begin
                    hunt_d = {dec_bit_c, hunt_q[7:1]};
                    if (hunt_d == SYNC_FLAG) begin
                        state_d        = RECV;
                        bit_cnt_d      = '0;
                        byte_cnt_d     = '0;
                        frame_active_d = 1'b1;
                    end
                end
                RECV: begin
                    shift_d   = {dec_bit_c, shift_q[DATA_W-1:1]};
                    bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    if (bit_cnt_q == BIT_CNT_W'(7)) begin
                        if (shift_d == SYNC_FLAG) begin
                            frame_end_d    = 1'b1;
                            frame_active_d = 1'b0;
                            state_d        = HUNT;
                            hunt_d         = '0;
                        end else if (byte_cnt_q == BYTE_CNT_W'(MAX_FRAME)) begin
                            err_length_d   = 1'b1;
                            frame_active_d = 1'b0;
                            state_d        = HUNT;
                            hunt_d         = '0;
                        end else begin
                            byte_cnt_d = byte_cnt_q + BYTE_CNT_W'(1);
                            new_byte_c = 1'b1;
                        end
                    end
                end
                default: begin
                    state_d = HUNT;
                end
            endcase
        end
    end

    // Holding register: a new byte may load on the same edge the old one drains.
    always_comb begin
        data_out_d    = data_out_q;
        data_valid_d  = data_valid_q;
        err_overrun_d = err_overrun_q;

        if (clr_err) begin
            err_overrun_d = 1'b0;
        end

        if (new_byte_c) begin
            if (!data_valid_q || dout.data_ready) begin
                data_out_d   = shift_d;
                data_valid_d = 1'b1;
            end else begin
                err_overrun_d = 1'b1;
            end
        end else if (data_valid_q && dout.data_ready) begin
            data_valid_d = 1'b0;
        end
    end

    assign dout.data_out   = data_out_q;
    assign dout.data_valid = data_valid_q;
    assign frame_active    = frame_active_q;
    assign frame_end       = frame_end_q;
    assign err_length      = err_length_q;
    assign err_overrun     = err_overrun_q;

endmodule

// File: tb/tb_nrzi_rx_deser.sv
// Bench for nrzi_rx_deser: NRZI stimulus, byte scoreboard, pulse/flag checks.
module tb_nrzi_rx_deser;
    import nrzi_pkg::*;

    logic clock;
    logic reset;
    logic rx_in;
    logic rx_en;
    logic clr_err;
    logic frame_active;
    logic frame_end;
    logic err_length;
    logic err_overrun;

    nrzi_rx_deser_if bus ();

    nrzi_rx_deser dut (
        .clock        (clock),
        .reset        (reset),
        .rx_in        (rx_in),
        .rx_en        (rx_en),
        .clr_err      (clr_err),
        .dout         (bus.master),
        .frame_active (frame_active),
        .frame_end    (frame_end),
        .err_length   (err_length),
        .err_overrun  (err_overrun)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int unsigned n_checks = 0;
    int unsigned n_pass   = 0;
    int unsigned n_len_pulses = 0;
    logic [7:0]  sb_q[$];
    logic        tx_line;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got=0x%0h expected=0x%0h (t=%0t)", tag, got, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    // Scoreboard consumer: every accepted byte must match the oldest expected one.
    always @(negedge clock) begin
        if (reset) begin
            if (err_length) n_len_pulses++;
            if (bus.data_valid && bus.data_ready) begin
                if (sb_q.size() == 0) begin
                    check("sb_unexpected_byte", {24'h0, bus.data_out}, 32'hFFFF_FFFF);
                end else begin
                    check("sb_byte", {24'h0, bus.data_out}, {24'h0, sb_q.pop_front()});
                end
            end
        end
    end

    // One NRZI bit: a 0 toggles the line, a 1 holds it.
    task automatic send_bit(input logic b);
        if (!b) tx_line = ~tx_line;
        rx_in = tx_line;
        rx_en = 1'b1;
        @(posedge clock);
        #1;
        rx_en = 1'b0;
    endtask

    // Strobe-off cycle with a garbage line level that must be ignored.
    task automatic idle(input int unsigned n);
        for (int k = 0; k < int'(n); k++) begin
            rx_en = 1'b0;
            rx_in = 1'($urandom);
            @(posedge clock);
            #1;
        end
        rx_in = tx_line;
    endtask

    task automatic send_byte(input logic [7:0] b, input logic gap);
        for (int i = 0; i < 8; i++) begin
            send_bit(b[i]);
            if (gap) idle(1);
        end
    endtask

    initial begin
        reset   = 1'b0;
        rx_in   = 1'b1;
        rx_en   = 1'b0;
        clr_err = 1'b0;
        bus.data_ready = 1'b0;
        tx_line = 1'b1;

        repeat (3) @(posedge clock);
        #1;
        check("rst_data_valid",   32'(bus.data_valid), 32'h0);
        check("rst_data_out",     32'(bus.data_out),   32'h0);
        check("rst_frame_active", 32'(frame_active),   32'h0);
        check("rst_frame_end",    32'(frame_end),      32'h0);
        check("rst_err_length",   32'(err_length),     32'h0);
        check("rst_err_overrun",  32'(err_overrun),    32'h0);
        reset = 1'b1;
        @(posedge clock);
        #1;

        // Opening flag: line 0,0,0,0,0,0,0,1 from idle high.
        bus.data_ready = 1'b1;
        send_byte(SYNC_FLAG, 1'b0);
        check("open_frame_active", 32'(frame_active),   32'h1);
        check("open_no_valid",     32'(bus.data_valid), 32'h0);

        // Single payload byte, valid right after the 8th bit edge.
        sb_q.push_back(8'hA5);
        send_byte(8'hA5, 1'b0);
        check("a5_valid",    32'(bus.data_valid), 32'h1);
        check("a5_data_out", 32'(bus.data_out),   32'hA5);
        idle(1);
        check("a5_valid_one_cycle", 32'(bus.data_valid), 32'h0);
        check("a5_data_held",       32'(bus.data_out),   32'hA5);

        // Closing flag.
        send_byte(SYNC_FLAG, 1'b0);
        check("close_frame_end",    32'(frame_end),    32'h1);
        check("close_frame_active", 32'(frame_active), 32'h0);
        idle(1);
        check("close_frame_end_pulse", 32'(frame_end), 32'h0);

        // Overrun: consumer stalled across two bytes.
        bus.data_ready = 1'b0;
        send_byte(SYNC_FLAG, 1'b0);
        sb_q.push_back(8'h11);
        send_byte(8'h11, 1'b0);
        check("ovr_no_err_yet", 32'(err_overrun), 32'h0);
        send_byte(8'h22, 1'b0);
        check("ovr_data_kept", 32'(bus.data_out),   32'h11);
        check("ovr_valid",     32'(bus.data_valid), 32'h1);
        check("ovr_sticky",    32'(err_overrun),    32'h1);
        idle(2);
        check("ovr_still_sticky", 32'(err_overrun), 32'h1);
        clr_err = 1'b1;
        @(posedge clock);
        #1;
        clr_err = 1'b0;
        check("ovr_cleared", 32'(err_overrun), 32'h0);
        bus.data_ready = 1'b1;
        @(posedge clock);
        #1;
        check("ovr_drained", 32'(bus.data_valid), 32'h0);
        send_byte(SYNC_FLAG, 1'b0);
        check("ovr_close", 32'(frame_end), 32'h1);

        // Over-length frame: 17 zero bytes, only 16 delivered.
        send_byte(SYNC_FLAG, 1'b0);
        for (int n = 0; n < 17; n++) begin
            if (n < int'(MAX_FRAME)) sb_q.push_back(8'h00);
            send_byte(8'h00, 1'b0);
            if (n == int'(MAX_FRAME) - 1) begin
                check("len_16th_active", 32'(frame_active), 32'h1);
            end
        end
        check("len_err_pulse",    32'(err_length),   32'h1);
        check("len_frame_active", 32'(frame_active), 32'h0);
        check("len_no_17th",      32'(bus.data_valid), 32'h0);
        idle(1);
        check("len_err_one_cycle", 32'(err_length), 32'h0);
        check("len_pulse_count",   n_len_pulses,    32'd1);

        // Strobe gating: same byte continuous and with rx_en toggling.
        send_byte(SYNC_FLAG, 1'b0);
        sb_q.push_back(8'h3C);
        send_byte(8'h3C, 1'b0);
        check("gate_cont_data", 32'(bus.data_out), 32'h3C);
        idle(1);
        sb_q.push_back(8'h3C);
        bus.data_ready = 1'b0;
        send_byte(8'h3C, 1'b1);
        check("gate_toggle_valid", 32'(bus.data_valid), 32'h1);
        check("gate_toggle_data",  32'(bus.data_out),   32'h3C);
        bus.data_ready = 1'b1;
        @(posedge clock);
        #1;

        // Reset mid-byte with a pending byte and an open frame.
        bus.data_ready = 1'b0;
        send_byte(8'h5A, 1'b0);
        check("mid_pending", 32'(bus.data_valid), 32'h1);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        reset = 1'b0;
        #1;
        check("mid_rst_valid",    32'(bus.data_valid), 32'h0);
        check("mid_rst_data_out", 32'(bus.data_out),   32'h0);
        check("mid_rst_active",   32'(frame_active),   32'h0);
        check("mid_rst_overrun",  32'(err_overrun),    32'h0);
        tx_line = 1'b1;
        rx_in   = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b1;
        bus.data_ready = 1'b1;

        // Recovery frame after reset.
        send_byte(SYNC_FLAG, 1'b0);
        check("rec_active", 32'(frame_active), 32'h1);
        sb_q.push_back(8'h81);
        send_byte(8'h81, 1'b0);
        check("rec_data", 32'(bus.data_out), 32'h81);
        send_byte(SYNC_FLAG, 1'b0);
        check("rec_frame_end", 32'(frame_end), 32'h1);
        idle(3);

        check("sb_drained", sb_q.size(), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got=running expected=finished");
        $fatal(1);
    end

endmodule

// File: doc/nrzi_rx_deser.md
Name: nrzi_rx_deser

Overview:
Receive end of the team's serial line path. The transmit side drives the line NRZI-encoded: it inverts the line for a 0 bit and holds it for a 1 bit.
This block decodes the NRZI line and hunts for the 8-bit frame flag. It then deserialises LSB-first data bytes and hands each byte to the consumer over a valid/ready handshake. Frame end, overrun and over-length frames are reported.

Parameters:
DATA_W, 8, byte width; fixed at 8 for this revision.
SYNC, 8'h7E, frame flag pattern, used as both opening and closing flag. It is never valid as payload.
MAX_FRAME, 16, maximum payload bytes per frame before abort.

Ports:
clock  input  1  system clock; all state changes on its rising edge.
reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
rx_in  input  1  NRZI line, already synchronised to clock.
rx_en  input  1  bit strobe; rx_in is a valid bit only in cycles where rx_en=1.
data_out  output  DATA_W  received payload byte; stable while data_valid=1.
data_valid  output  1  payload byte available.
data_ready  input  1  consumer accepts data_out when data_valid=1 and data_ready=1.
frame_active  output  1  high between opening flag and closing flag or abort.
frame_end  output  1  one-cycle pulse when the closing flag is received.
err_length  output  1  one-cycle pulse when a frame exceeds MAX_FRAME bytes.
err_overrun  output  1  sticky; a payload byte was dropped because the holding register was still full.
clr_err  input  1  synchronous clear of err_overrun.

Behaviour:
- Reset (reset=0, asynchronous):
  - prev_line=1 (idle line high).
  - state=HUNT; hunt_reg=0, shift_reg=0, bit_cnt=0, byte_cnt=0.
  - data_out=0, data_valid=0, frame_active=0, frame_end=0, err_length=0, err_overrun=0.
- Bit decode:
  - Performed only on edges where rx_en=1: bit = (rx_in == prev_line) ? 1 : 0; then prev_line <= rx_in.
  - When rx_en=0, no state other than the handshake changes.
- HUNT:
  - Each decoded bit enters hunt_reg at the MSB; hunt_reg shifts right.
  - When the updated hunt_reg equals SYNC: next state RECV, bit_cnt=0, byte_cnt=0, frame_active=1 from the same edge.
  - Data bits are ignored in HUNT.
- RECV:
  - Each decoded bit shifts into shift_reg at the MSB (LSB-first line order); bit_cnt increments.
  - On the 8th bit, the assembled byte is checked:
    - Byte == SYNC (closing flag): frame_end=1 for one cycle, frame_active=0, state=HUNT, hunt_reg=0. Back-to-back flags therefore need a fresh opening flag.
    - Byte != SYNC and byte_cnt == MAX_FRAME: err_length pulse, frame_active=0, state=HUNT, hunt_reg=0. Byte discarded.
    - Otherwise: byte_cnt+1, and the byte is offered to the holding register.
  - bit_cnt wraps 7 -> 0.
- Holding register / handshake:
  - Latency: data_valid=1 is visible after the edge that samples the 8th data bit.
  - Holding register free (data_valid=0) or emptying this edge (data_valid & data_ready): load data_out, data_valid=1.
  - Full and not accepted this edge: byte dropped, err_overrun=1, data_out unchanged.
  - Accept with no new byte: data_valid=0.
  - data_out is not cleared on accept.
- err_overrun stays high until clr_err=1 or reset. If set and clr_err occur on the same edge, set wins.
- A byte pending in the holding register survives frame_end and err_length; the consumer may still drain it.
- Reset mid-frame: everything returns to the reset values, including any pending byte.

Decomposition:
- Package nrzi_pkg:
  - SYNC_FLAG = 8'h7E.
  - State typedef: HUNT, RECV.
  - Byte-count width constant.
- Sub-module nrzi_bit_decoder:
  - Ports: clock, reset, rx_in, rx_en -> bit, bit_stb.
  - Holds prev_line and the equality compare. This keeps line decoding separate from the framing FSM and the handshake.

Test Plan:
- Opening flag: line after reset = 0,0,0,0,0,0,0,1 with rx_en=1 every cycle -> frame_active=1 after the 8th edge. data_valid stays 0.
- Payload byte: after the flag, send byte 8'hA5 NRZI-encoded LSB-first, data_ready=1 -> data_out=8'hA5, data_valid=1 for exactly one cycle. Visible after the 8th bit edge.
- Closing flag: after 8'hA5, send 8'h7E -> frame_end pulses once, frame_active=0. data_valid stays 0 during the flag.
- Overrun: data_ready=0, payload 8'h11 then 8'h22 -> data_out stays 8'h11, err_overrun=1. Then clr_err=1 -> err_overrun=0.
- Over-length frame: 17 payload bytes of 8'h00 with data_ready=1 -> 16 bytes delivered. err_length pulses on the 17th byte, frame_active=0, byte 17 not delivered.
- Reset and strobe gating:
  - reset pulled low at bit 4 of a byte -> all outputs 0 at once.
  - Same byte sent with rx_en toggling 1,0,1,0 -> identical data_out as with rx_en held at 1.
